dmem_responder: RTL and testbench

//  Data-memory responder for the RV32I core's load/store port: accepts one

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_lane_align.sv | 64 ++++++
 rtl/dmem_responder.sv | 102 ++++++++++
 tb/tb_dmem_responder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: RV32I size codes,
// FSM states, request record and the load-extension helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef logic [3:0] be_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Lane already shifted down to bit 0; widen it according to the load code.
  function automatic logic [31:0] extend_load(input logic [2:0] funct3, input logic [31:0] lane);
    case (funct3)
      F3_B:    return {{24{lane[7]}}, lane[7:0]};
      F3_BU:   return {24'b0, lane[7:0]};
      F3_H:    return {{16{lane[15]}}, lane[15:0]};
      F3_HU:   return {16'b0, lane[15:0]};
      default: return lane;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables, replicated store data, extended load
// data and access error. DMEM_MISALIGN_ERR_EN turns misaligned H/W into errors.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output be_t         be,
  output logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        err
);

  logic        is_half;
  logic        is_word;
  logic        legal;
  logic        misalign;
  logic [1:0]  lane_off;
  logic [31:0] lane;

  assign is_half = (funct3 == F3_H) || (funct3 == F3_HU);
  assign is_word = (funct3 == F3_W);

  // Stores have no unsigned variants, so BU/HU codes are illegal with we=1.
  assign legal = we ? ((funct3 == F3_B) || (funct3 == F3_H) || is_word)
                    : ((funct3 == F3_B) || (funct3 == F3_BU) || is_half || is_word);

`ifdef DMEM_MISALIGN_ERR_EN
  assign misalign = (is_half && offset[0]) || (is_word && (offset != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign err      = !legal || misalign;
  assign lane_off = is_word ? 2'b00 : (is_half ? {offset[1], 1'b0} : offset);
  assign lane     = rword >> {lane_off, 3'b000};

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    be         = '0;
    store_data = '0;
    load_data  = '0;
    if (!err) begin
      if (we) begin
        if (is_word) begin
          be         = 4'b1111;
          store_data = wdata;
        end else if (is_half) begin
          be         = 4'b0011 << lane_off;
          store_data = {2{wdata[15:0]}};
        end else begin
          be         = 4'b0001 << lane_off;
          store_data = {4{wdata[7:0]}};
        end
      end else begin
        load_data = extend_load(funct3, lane);
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states and
// on-chip RAM. Optional macro DMEM_MISALIGN_ERR_EN reports misaligned H/W accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t           state;
  logic [3:0]       wait_cnt;
  req_t             req_q;
  logic [31:0]      ram [DEPTH_WORDS];
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rword;
  logic [31:0]      store_data;
  logic [31:0]      load_data;
  be_t              be;
  logic             lane_err;
  logic             unused_addr_hi;

  // Address bits above the RAM depth are dropped, so accesses wrap.
  assign word_idx       = req_q.addr[IDX_W+1:2];
  assign unused_addr_hi = ^req_q.addr[31:IDX_W+2];
  assign rword          = ram[word_idx];
  assign req_ready      = (state == S_IDLE);

  dmem_lane_align u_lane_align (
    .we         (req_q.we),
    .funct3     (req_q.funct3),
    .offset     (req_q.addr[1:0]),
    .wdata      (req_q.wdata),
    .rword      (rword),
    .be         (be),
    .store_data (store_data),
    .load_data  (load_data),
    .err        (lane_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      req_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_q <= '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        S_RESP: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b1;
          rsp_rdata <= load_data;
          rsp_err   <= lane_err;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the RAM array is deliberately left out of reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if ((state == S_RESP) && req_q.we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram[word_idx][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: byte-level reference model with a
// per-cycle compare process, directed literal cases and randomized traffic.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int W     = 1;
  localparam int DEPTH = 256;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: byte-granular view of the access rules.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] word,
                                output logic [31:0] rdata, output logic err,
                                output logic [31:0] new_word);
    int size;
    int off;
    logic [31:0] v;
    rdata    = '0;
    err      = 1'b0;
    new_word = word;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (size == 0 || (we && f3[2])) begin
      err = 1'b1;
      return;
    end
    off = int'(addr[1:0]);
`ifdef DMEM_MISALIGN_ERR_EN
    if (off % size != 0) begin
      err = 1'b1;
      return;
    end
`endif
    off = off - (off % size);
    if (we) begin
      for (int i = 0; i < size; i++) new_word[8*(off+i) +: 8] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
      if (!f3[2] && size < 4 && v[8*size-1]) begin
        for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
      end
      rdata = v;
    end
  endfunction

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
    logic        wr;
    int          idx;
    logic [31:0] word;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem [DEPTH];
  int          ncyc       = 0;
  int          ready_from = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err   = 1'b0;

  // Compare process: every negedge, all outputs against the model.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] rd;
    logic        er;
    logic [31:0] nw;
    int          idx;
    ncyc++;
    if (!reset) begin
      q.delete();
      ready_from = 0;
      last_rdata = '0;
      last_err   = 1'b0;
      check("reset_req_ready", {31'b0, req_ready}, 32'd1);
      check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("reset_rsp_rdata", rsp_rdata, 32'd0);
      check("reset_rsp_err",   {31'b0, rsp_err}, 32'd0);
    end else begin
      check("req_ready", {31'b0, req_ready}, {31'b0, (ncyc >= ready_from)});
      if (q.size() > 0 && q[0].due == ncyc) begin
        e = q.pop_front();
        check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err",   {31'b0, rsp_err}, {31'b0, e.err});
        if (e.wr) mem[e.idx] = e.word;
        last_rdata = e.rdata;
        last_err   = e.err;
      end else begin
        check("rsp_valid_idle", {31'b0, rsp_valid}, 32'd0);
        check("rsp_rdata_hold", rsp_rdata, last_rdata);
        check("rsp_err_hold",   {31'b0, rsp_err}, {31'b0, last_err});
      end
      if (ncyc >= ready_from && req_valid) begin
        idx = int'(req_addr[9:2]);
        model(req_we, req_funct3, req_addr, req_wdata, mem[idx], rd, er, nw);
        e.due   = ncyc + W + 2;
        e.rdata = rd;
        e.err   = er;
        e.wr    = req_we && !er;
        e.idx   = idx;
        e.word  = nw;
        q.push_back(e);
        ready_from = ncyc + W + 2;
      end
    end
  end

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit hold);
    bit accepted;
    accepted = 1'b0;
    @(posedge clk);
    #1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    for (int i = 0; i < 40 && !accepted; i++) begin
      @(negedge clk);
      if (req_ready) accepted = 1'b1;
    end
    if (!accepted) begin
      check("accept_timeout", {31'b0, accepted}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid  = hold;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // Waits for the next response and pins it to hand-computed literals.
  task automatic expect_rsp(input string name, input logic [31:0] rd, input logic er,
                            output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        lat = n - 1;
      end
    end
    check({name, "_seen"}, {31'b0, got}, 32'd1);
    check({name, "_rdata"}, rsp_rdata, rd);
    check({name, "_err"}, {31'b0, rsp_err}, {31'b0, er});
  endtask

  task automatic settle();
    req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    bit          hold;

    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) txn(1'b1, F3_W, 32'(i * 4), $urandom, 1'b1);
    settle();

    // Reset mid-WAIT drops the pending store.
    txn(1'b1, F3_W, 32'h20, 32'h11112222, 1'b0);
    expect_rsp("t1_sw", 32'h0, 1'b0, lat);
    txn(1'b0, F3_W, 32'h20, 32'h0, 1'b0);
    expect_rsp("t1_lw_before", 32'h11112222, 1'b0, lat);
    txn(1'b1, F3_W, 32'h20, 32'h33334444, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    txn(1'b0, F3_W, 32'h20, 32'h0, 1'b0);
    expect_rsp("t1_lw_after", 32'h11112222, 1'b0, lat);

    txn(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b0);
    expect_rsp("t2_sw", 32'h0, 1'b0, lat);
    check("t2_sw_latency", 32'(lat), 32'd2);
    txn(1'b0, F3_W, 32'h10, 32'h0, 1'b0);
    expect_rsp("t2_lw", 32'hDEADBEEF, 1'b0, lat);
    check("t2_lw_latency", 32'(lat), 32'd2);

    txn(1'b1, F3_B, 32'h13, 32'h00000080, 1'b0);
    expect_rsp("t3_sb", 32'h0, 1'b0, lat);
    txn(1'b0, F3_B, 32'h13, 32'h0, 1'b0);
    expect_rsp("t3_lb", 32'hFFFFFF80, 1'b0, lat);
    txn(1'b0, F3_BU, 32'h13, 32'h0, 1'b0);
    expect_rsp("t3_lbu", 32'h00000080, 1'b0, lat);
    txn(1'b0, F3_W, 32'h10, 32'h0, 1'b0);
    expect_rsp("t3_lw", 32'h80ADBEEF, 1'b0, lat);

    txn(1'b1, F3_H, 32'h12, 32'h00001234, 1'b0);
    expect_rsp("t4_sh", 32'h0, 1'b0, lat);
    txn(1'b0, F3_HU, 32'h12, 32'h0, 1'b0);
    expect_rsp("t4_lhu", 32'h00001234, 1'b0, lat);
    txn(1'b0, F3_H, 32'h10, 32'h0, 1'b0);
    expect_rsp("t4_lh", 32'hFFFFBEEF, 1'b0, lat);

    txn(1'b0, F3_W, 32'h11, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_ERR_EN
    expect_rsp("t5_lw_mis", 32'h0, 1'b1, lat);
`else
    expect_rsp("t5_lw_mis", 32'h1234BEEF, 1'b0, lat);
`endif

    txn(1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
    expect_rsp("undef_f3", 32'h0, 1'b1, lat);

    // Wrap-around with req_valid held high across both transactions.
    txn(1'b1, F3_W, 32'h400, 32'hA5A5A5A5, 1'b1);
    txn(1'b0, F3_W, 32'h0, 32'h0, 1'b1);
    expect_rsp("t6_wrap", 32'hA5A5A5A5, 1'b0, lat);
    settle();

    for (int i = 0; i < 400; i++) begin
      we   = 1'($urandom);
      f3   = ($urandom_range(0, 7) == 0) ? 3'($urandom) :
             (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
      addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
      hold = ($urandom_range(0, 3) == 0);
      txn(we, f3, addr, $urandom, hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    settle();
    repeat (4) @(posedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
